// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, flush and operand-forwarding control for the 5-stage MIPS-32 pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_forward_ctrl #(
    parameter int REG_AW  = 5,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush_req,
    output logic              stall,
    output logic              flush,
    output logic              ex_bubble,
    output logic              fwd_a_mem,
    output logic              fwd_a_wb,
    output logic              fwd_b_mem,
    output logic              fwd_b_wb,
    output logic              id_byp_a,
    output logic              id_byp_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef logic [REG_AW-1:0] reg_t;

    typedef struct packed {
        logic v;
        reg_t rs;
        reg_t rt;
        logic use_rs;
        logic use_rt;
        reg_t dst;
        logic wr;
        logic ld;
    } ex_rec_t;

    typedef struct packed {
        logic v;
        reg_t dst;
        logic wr;
        logic ld;
    } pipe_rec_t;

    ex_rec_t   ex_q;
    ex_rec_t   ex_d;
    pipe_rec_t mem_q;
    pipe_rec_t wb_q;

    logic ex_hit_rs;
    logic ex_hit_rt;
    logic ld_use;
    logic stall_int;
    logic bubble_int;
    logic accept;
    logic a_mem;
    logic a_wb;
    logic b_mem;
    logic b_wb;
    logic byp_a;
    logic byp_b;
    logic unused_wb_ld;

    // Register 0 is hardwired, so it never counts as a producer when R0_ZERO is set.
    function automatic logic hit(
        input reg_t r,
        input logic v,
        input logic wr,
        input reg_t dst
    );
        hit = v & wr & (dst == r) & ~(R0_ZERO && (r == '0));
    endfunction

    assign ex_hit_rs = hit(id_rs, ex_q.v, ex_q.wr, ex_q.dst);
    assign ex_hit_rt = hit(id_rt, ex_q.v, ex_q.wr, ex_q.dst);

    assign ld_use = id_valid & ex_q.ld
                  & ((id_use_rs & ex_hit_rs) | (id_use_rt & ex_hit_rt));

    assign stall_int  = ld_use & ~flush_req;
    assign bubble_int = stall_int | flush_req | ~id_valid;
    assign accept     = ~bubble_int;

    always_comb begin
        ex_d = '0;
        if (accept) begin
            ex_d.v      = 1'b1;
            ex_d.rs     = id_rs;
            ex_d.rt     = id_rt;
            ex_d.use_rs = id_use_rs;
            ex_d.use_rt = id_use_rt;
            ex_d.dst    = id_dst;
            ex_d.wr     = id_regwrite;
            ex_d.ld     = id_memread;
        end
    end

    // Records always advance; a stall only replaces the EX entry with a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q.v   <= ex_q.v;
            mem_q.dst <= ex_q.dst;
            mem_q.wr  <= ex_q.wr;
            mem_q.ld  <= ex_q.ld;
            wb_q      <= mem_q;
        end
    end

    // A load in MEM has no data yet; its consumer is delayed until WB.
    assign a_mem = ex_q.v & ex_q.use_rs
                 & hit(ex_q.rs, mem_q.v, mem_q.wr, mem_q.dst) & ~mem_q.ld;
    assign a_wb  = ex_q.v & ex_q.use_rs
                 & hit(ex_q.rs, wb_q.v, wb_q.wr, wb_q.dst) & ~a_mem;
    assign b_mem = ex_q.v & ex_q.use_rt
                 & hit(ex_q.rt, mem_q.v, mem_q.wr, mem_q.dst) & ~mem_q.ld;
    assign b_wb  = ex_q.v & ex_q.use_rt
                 & hit(ex_q.rt, wb_q.v, wb_q.wr, wb_q.dst) & ~b_mem;

    assign byp_a = id_valid & id_use_rs & hit(id_rs, wb_q.v, wb_q.wr, wb_q.dst);
    assign byp_b = id_valid & id_use_rt & hit(id_rt, wb_q.v, wb_q.wr, wb_q.dst);

    assign unused_wb_ld = wb_q.ld;

    // Every control line is quiet while reset is held.
    assign stall     = rst_n & stall_int;
    assign flush     = rst_n & flush_req;
    assign ex_bubble = rst_n & bubble_int;
    assign fwd_a_mem = rst_n & a_mem;
    assign fwd_a_wb  = rst_n & a_wb;
    assign fwd_b_mem = rst_n & b_mem;
    assign fwd_b_wb  = rst_n & b_wb;
    assign id_byp_a  = rst_n & byp_a;
    assign id_byp_b  = rst_n & byp_b;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_int && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_req && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed cycle-by-cycle vectors for hazard_forward_ctrl.
// Optional HAZARD_STATS_EN section checks the stall/flush counters.
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] id_dst;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush_req;
    logic       stall;
    logic       flush;
    logic       ex_bubble;
    logic       fwd_a_mem;
    logic       fwd_a_wb;
    logic       fwd_b_mem;
    logic       fwd_b_wb;
    logic       id_byp_a;
    logic       id_byp_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    hazard_forward_ctrl #(
        .REG_AW (5),
        .R0_ZERO(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_dst     (id_dst),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush_req  (flush_req),
        .stall      (stall),
        .flush      (flush),
        .ex_bubble  (ex_bubble),
        .fwd_a_mem  (fwd_a_mem),
        .fwd_a_wb   (fwd_a_wb),
        .fwd_b_mem  (fwd_b_mem),
        .fwd_b_wb   (fwd_b_wb),
        .id_byp_a   (id_byp_a),
        .id_byp_b   (id_byp_b)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bits: {stall,flush,bubble,a_mem,a_wb,b_mem,b_wb,byp_a,byp_b}
    localparam logic [8:0] S  = 9'b100000000;
    localparam logic [8:0] F  = 9'b010000000;
    localparam logic [8:0] X  = 9'b001000000;
    localparam logic [8:0] AM = 9'b000100000;
    localparam logic [8:0] AW = 9'b000010000;
    localparam logic [8:0] BM = 9'b000001000;
    localparam logic [8:0] BW = 9'b000000100;
    localparam logic [8:0] PA = 9'b000000010;
    localparam logic [8:0] PB = 9'b000000001;
    localparam logic [8:0] Z  = 9'b000000000;

    typedef struct {
        string      name;
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       ut;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
        logic       fl;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    function automatic vec_t mk(
        input string nm, input bit rst, input bit v,
        input int rs, input int rt, input bit ur, input bit ut,
        input int dst, input bit wr, input bit ld, input bit fl,
        input logic [8:0] e
    );
        vec_t r;
        r.name = nm;
        r.rst  = rst;
        r.v    = v;
        r.rs   = 5'(rs);
        r.rt   = 5'(rt);
        r.ur   = ur;
        r.ut   = ut;
        r.dst  = 5'(dst);
        r.wr   = wr;
        r.ld   = ld;
        r.fl   = fl;
        r.exp  = e;
        return r;
    endfunction

    function automatic vec_t nop(input string nm, input logic [8:0] e);
        return mk(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst_n       = t.rst;
        id_valid    = t.v;
        id_rs       = t.rs;
        id_rt       = t.rt;
        id_use_rs   = t.ur;
        id_use_rt   = t.ut;
        id_dst      = t.dst;
        id_regwrite = t.wr;
        id_memread  = t.ld;
        flush_req   = t.fl;
    endtask

    function automatic logic [8:0] outs();
        return {stall, flush, ex_bubble, fwd_a_mem, fwd_a_wb,
                fwd_b_mem, fwd_b_wb, id_byp_a, id_byp_b};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        drive(nop("init", Z));
        rst_n = 1'b0;

        vecs.push_back(mk("rst_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z));
        vecs.push_back(mk("rst_valid", 0, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(mk("add3",      1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(mk("sub_id",    1, 1, 3, 4, 1, 1, 5, 1, 0, 0, Z));
        vecs.push_back(nop("sub_ex_mem", X | AM));
        vecs.push_back(mk("add3_d2",   1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(nop("gap_d2", X));
        vecs.push_back(mk("or_id_d2",  1, 1, 3, 3, 1, 1, 6, 1, 0, 0, Z));
        vecs.push_back(nop("or_ex_wb", X | AW | BW));
        vecs.push_back(mk("add3_d3",   1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(nop("gap_d3a", X));
        vecs.push_back(nop("gap_d3b", X));
        vecs.push_back(mk("or_id_byp", 1, 1, 3, 7, 1, 1, 6, 1, 0, 0, PA));
        vecs.push_back(nop("or_ex_d3", X));
        vecs.push_back(mk("lw8",       1, 1, 1, 8, 1, 0, 8, 1, 1, 0, Z));
        vecs.push_back(mk("lu_stall",  1, 1, 8, 1, 1, 1, 9, 1, 0, 0, S | X));
        vecs.push_back(mk("lu_release",1, 1, 8, 1, 1, 1, 9, 1, 0, 0, Z));
        vecs.push_back(nop("lu_ex_wb", X | AW));
        vecs.push_back(mk("lw10",      1, 1, 1, 10, 1, 0, 10, 1, 1, 0, Z));
        vecs.push_back(mk("flush_lu",  1, 1, 10, 10, 1, 1, 11, 1, 0, 1, F | X));
        vecs.push_back(nop("post_flush", X));
        vecs.push_back(mk("add_r0",    1, 1, 1, 2, 1, 1, 0, 1, 0, 0, Z));
        vecs.push_back(mk("use_r0_id", 1, 1, 0, 0, 1, 1, 4, 1, 0, 0, Z));
        vecs.push_back(nop("use_r0_ex", X));
        vecs.push_back(mk("r0_wb_byp", 1, 1, 0, 0, 1, 1, 5, 1, 0, 0, Z));
        vecs.push_back(mk("lw_r0",     1, 1, 1, 0, 1, 0, 0, 1, 1, 0, Z));
        vecs.push_back(mk("lu_r0",     1, 1, 0, 0, 1, 1, 6, 1, 0, 0, Z));
        vecs.push_back(mk("add3_pre",  1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(mk("mid_rst",   0, 1, 3, 3, 1, 1, 5, 1, 0, 1, Z));
        vecs.push_back(mk("post_rst",  1, 1, 3, 3, 1, 1, 5, 1, 0, 0, Z));
        vecs.push_back(nop("no_stale", X));
        vecs.push_back(mk("pri_add1",  1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(mk("pri_add2",  1, 1, 1, 2, 1, 1, 3, 1, 0, 0, Z));
        vecs.push_back(mk("pri_sub",   1, 1, 3, 4, 1, 1, 5, 1, 0, 0, Z));
        vecs.push_back(nop("pri_mem_wins", X | AM));
        vecs.push_back(mk("byp_b",     1, 1, 1, 3, 1, 1, 7, 1, 0, 0, PB));
        vecs.push_back(mk("and8",      1, 1, 2, 7, 1, 1, 8, 1, 0, 0, Z));
        vecs.push_back(nop("b_mem", X | BM));
        vecs.push_back(nop("tail", X));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

`ifdef HAZARD_STATS_EN
        @(posedge clk);
        #1;
        drive(mk("s_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z));
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            drive(mk("s_lw", 1, 1, 1, 8, 1, 0, 8, 1, 1, 0, Z));
            @(posedge clk);
            #1;
            drive(mk("s_use", 1, 1, 8, 1, 1, 1, 9, 1, 0, 0, Z));
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
        end
        drive(mk("s_fl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive(nop("s_idle", X));
        @(negedge clk);
        check("stall_cnt", stall_cnt, 32'd3);
        check("flush_cnt", flush_cnt, 32'd2);
        @(posedge clk);
        #1;
        drive(mk("s_rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, Z));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_cnt_rst", stall_cnt, 32'd0);
        check("flush_cnt_rst", flush_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
